regfile_wb_scheduler: RTL
=========================

Name: regfile_wb_scheduler

Overview:
- Sequences access to the 32x32 RV32I register file.
- Shares its single write port (A3/WD3/RegWrite) between two writeback requesters: the load unit (LSU) and the ALU/execute pipe.
- Keeps a per-register busy scoreboard so issue stalls on RAW/WAW hazards against in-flight writes.
- Sits between decode/issue, the two writeback sources and register_file.

Parameters:
- XLEN, 32, data width of WD3 and the writeback data ports.
- STARVE_LIMIT, 4, consecutive lost ALU arbitration cycles before the ALU is forced to win one cycle; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_rs1  in  5  source register 1.
- issue_rs2  in  5  source register 2.
- issue_rd  in  5  destination register.
- issue_we  in  1  instruction writes rd.
- issue_stall  out  1  hazard; issue must hold its instruction.
- lsu_valid  in  1  load writeback request.
- lsu_rd  in  5  load destination.
- lsu_data  in  XLEN  load data.
- lsu_ready  out  1  load writeback accepted this cycle.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  5  ALU destination.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU writeback accepted this cycle.
- rf_we  out  1  to RegWrite.
- rf_a3  out  5  to A3.
- rf_wd3  out  XLEN  to WD3.
- wb_err  out  1  sticky protocol-error flag.

Behaviour:
- State: busy[31:1] (busy[0] is constant 0); starve_cnt (4 bits); wb_err.
- Reset: all state clears asynchronously.
- Outputs while reset is held: issue_stall=0, lsu_ready=0, alu_ready=0, rf_we=0, rf_a3=0, rf_wd3=0, wb_err=0.
- Hazard (combinational):
  - haz = busy[issue_rs1] | busy[issue_rs2] | (issue_we & busy[issue_rd]).
  - issue_stall = issue_valid & haz.
  - x0 never stalls.
- Issue fire: issue_valid & ~issue_stall & issue_we & issue_rd!=0 sets busy[issue_rd] at the edge.
- Arbitration (combinational, single write port, zero latency):
  - ALU is forced to win when starve_cnt==STARVE_LIMIT and alu_valid. Otherwise the LSU has priority.
  - Grant asserts the winner's ready. The loser's ready is 0 and it must hold its request (valid/ready, data stable).
  - rf_a3/rf_wd3 come from the winner. rf_we = grant & rd!=0.
  - With no request: rf_we=0, rf_a3=0, rf_wd3=0.
- starve_cnt:
  - Increments when alu_valid & ~alu_ready.
  - Clears when alu_ready, or when alu_valid=0.
  - Saturates at STARVE_LIMIT.
- Writeback fire clears busy[rd] at the edge.
  - If rd!=0 and busy[rd]==0, set wb_err (sticky until reset). The write still proceeds.
- Simultaneous issue-set and writeback-clear of the same rd cannot occur legally, because of the WAW stall. If it does occur, set wins.
- Reset mid-operation: busy is cleared and in-flight writebacks are forgotten. Upstream flushes on the same reset.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: a register being written by the granted writeback this cycle is treated as not busy in the hazard check. The stall drops in the same cycle as the write, and a dependent issue proceeds next edge, reading the new value through the register file.
- Undefined: the hazard check uses registered busy only, costing one extra stall cycle after each writeback.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN and REG_ADDR_W=5.
  - typedef reg_addr_t.
  - typedef wb_req_t {valid, rd, data}.
  - constant REG_ZERO=5'd0.
- One natural sub-module: wb_port_arbiter (priority plus starvation counter, outputs grant and mux).
- The scoreboard stays in regfile_wb_scheduler.

Test Plan:
- Reset, then issue rd=5 with issue_we: busy[5]=1. Next cycle issue rs1=5 → issue_stall=1. ALU writeback rd=5 data=0x1234 → rf_we=1, rf_a3=5, rf_wd3=0x1234. Stall drops the following cycle, or the same cycle with REGFILE_WB_BYPASS_EN.
- LSU and ALU both valid (rd=3, rd=4): lsu_ready=1, alu_ready=0, rf_a3=3. Next cycle, with LSU idle, the ALU is granted, rf_a3=4.
- LSU valid continuously and ALU valid: ALU loses 4 cycles. In cycle 5 alu_ready=1 and lsu_ready=0. starve_cnt returns to 0.
- Issue rd=0 with issue_we: busy unchanged, no stall. Writeback rd=0 → ready=1, rf_we=0, wb_err stays 0.
- Writeback rd=9 while busy[9]=0 → write occurs, wb_err=1 and stays 1 until reset.
- Assert reset mid-stream with busy[7]=1 and ALU waiting → all busy bits clear, all outputs 0, issue rs1=7 does not stall after reset.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I register-file types: address width, writeback request bundle.
package rv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef struct packed {
    logic            valid;
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t a);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << a;
  endfunction
endpackage

// File: rtl/regfile_wb_scheduler_arbiter.sv
// wb_port_arbiter: LSU-priority arbiter for the single register-file write port,
// with a starvation counter that forces one ALU win after STARVE_LIMIT losses.
module wb_port_arbiter
  import rv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  wb_req_t lsu_req,
  input  wb_req_t alu_req,
  output logic    lsu_ready,
  output logic    alu_ready,
  output wb_req_t win
);

  logic [3:0] starve_cnt_reg;
  logic       force_alu;

  always_comb begin
    force_alu = alu_req.valid && (starve_cnt_reg == 4'(STARVE_LIMIT));
    lsu_ready = lsu_req.valid && !force_alu && !reset;
    alu_ready = alu_req.valid && (force_alu || !lsu_req.valid) && !reset;
    win       = '0;
    if (lsu_ready)      win = lsu_req;
    else if (alu_ready) win = alu_req;
  end

  // Counts only consecutive losses; any idle or granted ALU cycle restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  starve_cnt_reg <= 4'd0;
    else if (!alu_req.valid || alu_ready)       starve_cnt_reg <= 4'd0;
    else if (starve_cnt_reg != 4'(STARVE_LIMIT)) starve_cnt_reg <= starve_cnt_reg + 4'd1;
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: busy scoreboard for issue hazards plus a shared
// write port. Define REGFILE_WB_BYPASS_EN to let the granted write clear its hazard same-cycle.
module regfile_wb_scheduler
  import rv_pkg::*;
#(
  parameter int XLEN         = rv_pkg::XLEN,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  input  logic [4:0]      issue_rd,
  input  logic            issue_we,
  output logic            issue_stall,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  output logic            rf_we,
  output logic [4:0]      rf_a3,
  output logic [XLEN-1:0] rf_wd3,
  output logic            wb_err
);

  wb_req_t lsu_req, alu_req, win;
  logic [NUM_REGS-1:1] busy_reg;
  logic [NUM_REGS-1:0] busy_vec, busy_chk, clr_mask, set_mask;
  logic                wb_wr, haz, issue_fire, wb_err_reg;

  assign lsu_req = '{valid: lsu_valid, rd: lsu_rd, data: lsu_data};
  assign alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};

  wb_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .lsu_req   (lsu_req),
    .alu_req   (alu_req),
    .lsu_ready (lsu_ready),
    .alu_ready (alu_ready),
    .win       (win)
  );

  always_comb begin
    busy_vec = {busy_reg, 1'b0};
    wb_wr    = win.valid && (win.rd != REG_ZERO);
    clr_mask = wb_wr ? reg_onehot(win.rd) : '0;
`ifdef REGFILE_WB_BYPASS_EN
    busy_chk = busy_vec & ~clr_mask;
`else
    busy_chk = busy_vec;
`endif
    haz         = busy_chk[issue_rs1] | busy_chk[issue_rs2] | (issue_we & busy_chk[issue_rd]);
    issue_stall = issue_valid && haz && !reset;
    issue_fire  = issue_valid && !issue_stall && issue_we && (issue_rd != REG_ZERO);
    set_mask    = issue_fire ? reg_onehot(issue_rd) : '0;
    rf_we       = wb_wr;
    rf_a3       = win.rd;
    rf_wd3      = win.data;
  end

  // Set is applied after clear so an illegal same-cycle collision leaves rd busy.
  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
    always_ff @(posedge clk or posedge reset) begin
      if (reset) busy_reg[gi] <= 1'b0;
      else       busy_reg[gi] <= (busy_reg[gi] & ~clr_mask[gi]) | set_mask[gi];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         wb_err_reg <= 1'b0;
    else if (wb_wr && !busy_vec[win.rd]) wb_err_reg <= 1'b1;
  end

  assign wb_err = wb_err_reg;

endmodule
